// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 1W/2R register file, byte-lane writes, registered reads.
// Optional write-to-read bypass and a one-entry-per-cycle clear sequencer.
module reg_file_2r1w #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int BYPASS = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               WrEn,
    input  logic [AW-1:0]      WrAddr,
    input  logic [WIDTH-1:0]   WrData,
    input  logic [WIDTH/8-1:0] WrByteEn,
    input  logic               RdEnA,
    input  logic [AW-1:0]      RdAddrA,
    output logic [WIDTH-1:0]   RdDataA,
    output logic               RdValidA,
    output logic               RdErrA,
    input  logic               RdEnB,
    input  logic [AW-1:0]      RdAddrB,
    output logic [WIDTH-1:0]   RdDataB,
    output logic               RdValidB,
    output logic               RdErrB,
    input  logic               ClrReq,
    output logic               Busy
);

    localparam int NB = WIDTH / 8;
    localparam logic [AW:0] LIM = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } clr_state_t;

    logic [WIDTH-1:0] mem [DEPTH];

    clr_state_t       state_q;
    clr_state_t       state_d;
    logic [AW-1:0]    ptr_q;
    logic [AW-1:0]    ptr_d;
    logic             busy_q;
    logic             busy_d;
    logic             clr_en;

    logic             wr_oob;
    logic             wr_ok;
    logic [WIDTH-1:0] wr_old;
    logic [WIDTH-1:0] wr_merged;

    logic             oob_a;
    logic             oob_b;
    logic             hit_a;
    logic             hit_b;
    logic [WIDTH-1:0] rd_nxt_a;
    logic [WIDTH-1:0] rd_nxt_b;

    // Write qualification: in range, not clearing.
    always_comb begin
        wr_oob = ({1'b0, WrAddr} >= LIM);
        wr_ok  = WrEn && !busy_q && !wr_oob;
    end

    // Merge enabled byte lanes of WrData over the current entry.
    always_comb begin
        wr_old    = '0;
        wr_merged = '0;
        if (!wr_oob) begin
            wr_old = mem[WrAddr];
        end
        for (int b = 0; b < NB; b++) begin
            if (WrByteEn[b]) begin
                wr_merged[8*b +: 8] = WrData[8*b +: 8];
            end else begin
                wr_merged[8*b +: 8] = wr_old[8*b +: 8];
            end
        end
    end

    // Clear sequencer next-state and per-cycle clear strobe.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        clr_en  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ClrReq) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_CLEAR: begin
                clr_en = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == LAST) begin
                    state_d = S_IDLE;
                    ptr_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                ptr_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Clear sequencer state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    assign Busy = busy_q;

    // Storage array: reset, clear sweep, or accepted write.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_en) begin
            mem[ptr_q] <= '0;
        end else if (wr_ok) begin
            mem[WrAddr] <= wr_merged;
        end
    end

    // Next read data per port, with optional forwarding.
    always_comb begin
        oob_a    = ({1'b0, RdAddrA} >= LIM);
        oob_b    = ({1'b0, RdAddrB} >= LIM);
        hit_a    = (BYPASS != 0) && wr_ok && (RdAddrA == WrAddr);
        hit_b    = (BYPASS != 0) && wr_ok && (RdAddrB == WrAddr);
        rd_nxt_a = '0;
        rd_nxt_b = '0;
        if (!oob_a) begin
            rd_nxt_a = hit_a ? wr_merged : mem[RdAddrA];
        end
        if (!oob_b) begin
            rd_nxt_b = hit_b ? wr_merged : mem[RdAddrB];
        end
    end

    // Port A output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            RdDataA  <= '0;
            RdValidA <= 1'b0;
            RdErrA   <= 1'b0;
        end else begin
            RdValidA <= RdEnA;
            RdErrA   <= RdEnA && oob_a;
            if (RdEnA) begin
                RdDataA <= rd_nxt_a;
            end
        end
    end

    // Port B output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            RdDataB  <= '0;
            RdValidB <= 1'b0;
            RdErrB   <= 1'b0;
        end else begin
            RdValidB <= RdEnB;
            RdErrB   <= RdEnB && oob_b;
            if (RdEnB) begin
                RdDataB <= rd_nxt_b;
            end
        end
    end

endmodule
